// File: rtl/seg_pkg.sv
// Shared types for the seven-segment scan controller.
// Optional build macro SEG_SCAN_BLINK_EN adds a per-digit blink bit to the entry.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  typedef struct packed {
`ifdef SEG_SCAN_BLINK_EN
    logic       blink;
`endif
    logic       blank;
    logic [3:0] nibble;
  } seg_entry_t;

  // Frames per blink half-period.
  localparam int BLINK_FRAMES = 32;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int width_of(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // Power-on table entry: digit dark, nibble zero, not blinking.
  function automatic seg_entry_t entry_reset();
    seg_entry_t e;
    e       = '0;
    e.blank = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan sequencer: dwell counter, digit index walk and end-of-frame pulse.
// Presents the state/index the display will be in next cycle so the top can
// register its outputs directly from them.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 1000,
  parameter int GAP_CYC  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  output scan_state_t               state_nxt,
  output logic [$clog2(DIGITS)-1:0] idx_nxt,
  output logic                      frame_done
);

  localparam int AW    = $clog2(DIGITS);
  localparam int CNT_W = width_of((SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [AW-1:0]    IDX_LAST  = AW'(DIGITS - 1);

  scan_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [AW-1:0]    idx_q;
  logic             fd_nxt;

  // State register: current scan position plus the registered frame pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      idx_q      <= idx_nxt;
      frame_done <= fd_nxt;
    end
  end

  // Next-state: dwell counting, digit advance with wrap, enable override.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q + CNT_W'(1);
    idx_nxt   = idx_q;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_nxt = GAP;
            cnt_nxt   = '0;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
            idx_nxt   = (idx_q == IDX_LAST) ? '0 : idx_q + AW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode: pulse during the final gap cycle of the last digit.
  always_comb begin
    fd_nxt = (state_nxt == GAP) && (idx_nxt == IDX_LAST) && (cnt_nxt == GAP_LAST);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller top: double-buffered digit tables, frame
// commit and registered segment/strobe outputs.
// Optional build macro SEG_SCAN_BLINK_EN adds wr_blink and a 32-frame blink phase.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 1000,
  parameter int GAP_CYC  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [$clog2(DIGITS)-1:0] wr_addr,
  input  logic [3:0]                wr_data,
  input  logic                      wr_blank,
`ifdef SEG_SCAN_BLINK_EN
  input  logic                      wr_blink,
`endif
  output logic [3:0]                seg_nibble,
  output logic                      seg_blank,
  output logic [DIGITS-1:0]         digit_sel,
  output logic                      frame_done
);

  localparam int AW = $clog2(DIGITS);

  seg_entry_t  shadow [DIGITS];
  seg_entry_t  active [DIGITS];
  seg_entry_t  wr_entry;
  seg_entry_t  src;
  scan_state_t state_nxt;
  logic [AW-1:0]     idx_nxt;
  logic              wr_hit;
  logic              commit;
  logic              blink_dark;
  logic [DIGITS-1:0] sel_nxt;
  logic              blank_nxt;
  logic [3:0]        nib_nxt;

  seg_scan_timer #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .GAP_CYC  (GAP_CYC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .state_nxt  (state_nxt),
    .idx_nxt    (idx_nxt),
    .frame_done (frame_done)
  );

  // The write port never stalls; it is only held off while in reset.
  assign wr_ready = rst;
  assign wr_hit   = wr_valid && wr_ready && (int'(wr_addr) < DIGITS);
  // Commit is suppressed if the scan is being disabled in the same cycle.
  assign commit   = frame_done && en;

  // Assemble the entry presented on the write port.
  always_comb begin
    wr_entry        = entry_reset();
    wr_entry.blank  = wr_blank;
    wr_entry.nibble = wr_data;
`ifdef SEG_SCAN_BLINK_EN
    wr_entry.blink  = wr_blink;
`endif
  end

  // Shadow table: takes host writes at any time, out-of-range addresses dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DIGITS; i++) shadow[i] <= entry_reset();
    end else if (wr_hit) begin
      shadow[wr_addr] <= wr_entry;
    end
  end

  // Active table: whole-frame copy of the shadow at the frame boundary, so a
  // write landing in the same cycle is seen only from the following frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DIGITS; i++) active[i] <= entry_reset();
    end else if (commit) begin
      active <= shadow;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES);

  logic [FW-1:0] frm_cnt;
  logic          blink_on;
  logic          blink_on_nxt;

  // Blink phase flips after every BLINK_FRAMES committed frames.
  always_comb begin
    blink_on_nxt = blink_on;
    if (commit && (frm_cnt == FW'(BLINK_FRAMES - 1))) blink_on_nxt = ~blink_on;
  end

  // Frame counter and blink phase; phase starts in the lit half.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frm_cnt  <= '0;
      blink_on <= 1'b1;
    end else begin
      if (commit) frm_cnt <= frm_cnt + FW'(1);
      blink_on <= blink_on_nxt;
    end
  end

  assign blink_dark = src.blink && !blink_on_nxt;
`else
  assign blink_dark = 1'b0;
`endif

  // Next output values; at a commit the incoming frame reads the shadow
  // directly because the active copy lands on the same edge.
  always_comb begin
    src       = commit ? shadow[idx_nxt] : active[idx_nxt];
    sel_nxt   = '1;
    blank_nxt = 1'b1;
    nib_nxt   = seg_nibble;
    if (state_nxt == SHOW) begin
      sel_nxt   = ~(DIGITS'(1) << idx_nxt);
      blank_nxt = src.blank || blink_dark;
      nib_nxt   = src.nibble;
    end
  end

  // Output register: strobe, blank and nibble all launched from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_sel  <= '1;
      seg_blank  <= 1'b1;
      seg_nibble <= 4'h0;
    end else begin
      digit_sel  <= sel_nxt;
      seg_blank  <= blank_nxt;
      seg_nibble <= nib_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (DIGITS=4, SCAN_DIV=4, GAP_CYC=1): directed steps
// followed by random writes/enable toggles, checked against a position-based
// reference model of the scan.
module tb_seg_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int GAP_CYC  = 1;
  localparam int SLOT     = SCAN_DIV + GAP_CYC;
  localparam int FRAME    = DIGITS * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [3:0] wr_data = 4'h0;
  logic       wr_blank = 1'b1;
  logic       wr_ready;
  logic [3:0] seg_nibble;
  logic       seg_blank;
  logic [3:0] digit_sel;
  logic       frame_done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: scan position counted from the first enabled cycle.
  int         m_pos;
  logic [4:0] m_sh  [DIGITS];
  logic [4:0] m_act [DIGITS];
  logic [3:0] m_nib;
  logic       m_fd;
  logic [3:0] e_sel;
  logic       e_blank;
  logic       e_fd;

  seg_scan_ctrl #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_blank   (wr_blank),
    .seg_nibble (seg_nibble),
    .seg_blank  (seg_blank),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    int p, d, o;
    if (m_pos < 0) begin
      e_sel   = 4'hF;
      e_blank = 1'b1;
      e_fd    = 1'b0;
    end else begin
      p = m_pos % FRAME;
      d = p / SLOT;
      o = p % SLOT;
      if (o < SCAN_DIV) begin
        e_sel   = ~(4'b0001 << d);
        e_blank = m_act[d][4];
        m_nib   = m_act[d][3:0];
      end else begin
        e_sel   = 4'hF;
        e_blank = 1'b1;
      end
      e_fd = (p == FRAME - 1);
    end
    m_fd = e_fd;
  endtask

  task automatic model_reset();
    m_pos = -1;
    for (int i = 0; i < DIGITS; i++) begin
      m_sh[i]  = 5'h10;
      m_act[i] = 5'h10;
    end
    m_nib = 4'h0;
    model_eval();
  endtask

  // Apply the inputs sampled at this clock edge to the model.
  task automatic model_edge();
    if (m_fd && en) begin
      for (int i = 0; i < DIGITS; i++) m_act[i] = m_sh[i];
    end
    if (wr_valid) m_sh[wr_addr] = {wr_blank, wr_data};
    if (en) m_pos = (m_pos < 0) ? 0 : m_pos + 1;
    else    m_pos = -1;
    model_eval();
  endtask

  task automatic check_outputs();
    chk("digit_sel",  32'(digit_sel),  32'(e_sel));
    chk("seg_blank",  32'(seg_blank),  32'(e_blank));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("seg_nibble", 32'(seg_nibble), 32'(m_nib));
    chk("wr_ready",   32'(wr_ready),   32'(rst));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check_outputs();
  endtask

  initial begin
    int guard;

    // Reset state.
    model_reset();
    #23;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Disabled: dark, no frame pulses.
    repeat (100) tick();

    // Load 1,2,3,4 then enable: first frame dark, second shows the values.
    for (int i = 0; i < DIGITS; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 2'(i);
      wr_data  = 4'(i + 1);
      wr_blank = 1'b0;
      tick();
    end
    wr_valid = 1'b0;
    en = 1'b1;
    repeat (2 * FRAME) tick();

    // Write digit 2 during a frame_done cycle.
    guard = 0;
    while (!m_fd && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    chk("fd_wait", 32'(frame_done), 32'd1);
    wr_valid = 1'b1;
    wr_addr  = 2'd2;
    wr_data  = 4'hA;
    wr_blank = 1'b0;
    tick();
    wr_valid = 1'b0;
    repeat (2 * FRAME) tick();

    // Drop enable while digit 1 is lit, then re-enable.
    guard = 0;
    while (!(m_pos >= 0 && (m_pos % FRAME) == SLOT + 1) && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    chk("dig1_wait", 32'(digit_sel), 32'h0000_000D);
    en = 1'b0;
    tick();
    repeat (3) tick();
    en = 1'b1;
    tick();
    chk("relit_dig0", 32'(digit_sel), 32'h0000_000E);

    // Random writes and enable toggles.
    for (int n = 0; n < 800; n++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_addr  = 2'($urandom);
      wr_data  = 4'($urandom);
      wr_blank = ($urandom_range(0, 4) == 0);
      if (en) begin
        if ($urandom_range(0, 99) == 0) en = 1'b0;
      end else begin
        if ($urandom_range(0, 2) == 0) en = 1'b1;
      end
      tick();
    end
    wr_valid = 1'b0;
    en = 1'b1;
    repeat (FRAME) tick();

    // Asynchronous reset in the middle of a gap.
    guard = 0;
    while (!(m_pos >= 0 && (m_pos % SLOT) == SCAN_DIV) && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    chk("gap_wait", 32'(digit_sel), 32'h0000_000F);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
    repeat (2 * FRAME) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
